// File: rtl/dmem_pkg.sv
// Shared constants for the data-memory controller: access size codes,
// FSM state encoding and the address-split helper.
package dmem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    // Number of byte-offset bits inside one word.
    function automatic int lsb_of(input int data_width);
        return $clog2(data_width / 8);
    endfunction

    function automatic int depth_of(input int data_width, input int addr_width);
        return 1 << (addr_width - lsb_of(data_width));
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational lane steering: builds the store byte mask and shifted store
// data, and extracts/extends the addressed bytes of a load.
module dmem_lane_align
    import dmem_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int LSB        = 2
) (
    input  logic [LSB-1:0]          off,
    input  logic [1:0]              size,
    input  logic                    sext,
    input  logic [DATA_WIDTH-1:0]   data_in,
    input  logic [DATA_WIDTH-1:0]   raw,
    output logic [DATA_WIDTH/8-1:0] wmask,
    output logic [DATA_WIDTH-1:0]   wdata_sh,
    output logic [DATA_WIDTH-1:0]   rdata_ext,
    output logic                    misalign
);

    localparam int NB = DATA_WIDTH / 8;
    localparam logic [DATA_WIDTH-1:0] M8  = DATA_WIDTH'(8'hFF);
    localparam logic [DATA_WIDTH-1:0] M16 = DATA_WIDTH'(16'hFFFF);

    logic [LSB+2:0]          sh;
    logic [DATA_WIDTH-1:0]   raw_sh;

    assign sh     = {off, 3'b000};
    assign raw_sh = raw >> sh;

    always_comb begin
        wmask     = '0;
        wdata_sh  = '0;
        rdata_ext = raw;
        misalign  = 1'b0;
        case (size)
            SZ_BYTE: begin
                wmask     = NB'(1) << off;
                wdata_sh  = (data_in & M8) << sh;
                rdata_ext = (sext && raw_sh[7]) ? (raw_sh | ~M8) : (raw_sh & M8);
            end
            SZ_HALF: begin
                // With 16-bit words this naturally degenerates to a full-word access.
                misalign  = off[0];
                wmask     = NB'(3) << off;
                wdata_sh  = (data_in & M16) << sh;
                rdata_ext = (sext && raw_sh[15]) ? (raw_sh | ~M16) : (raw_sh & M16);
            end
            SZ_WORD: begin
                misalign  = |off;
                wmask     = '1;
                wdata_sh  = data_in;
                rdata_ext = raw;
            end
            default: misalign = 1'b1;
        endcase
    end

endmodule

// File: rtl/dmem_ctrl.sv
// Parametrised MEM-stage data memory with sub-word access, alignment
// checking, registered single-cycle loads and a reset-time clear sequence.
module dmem_ctrl
    import dmem_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 10,
    parameter bit CLEAR_ON_RESET = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ram_ena,
    input  logic                  wena,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [1:0]            size,
    input  logic                  sext,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  rvalid,
    output logic                  err,
    output logic                  ready
);

    localparam int LSB   = lsb_of(DATA_WIDTH);
    localparam int NB    = DATA_WIDTH / 8;
    localparam int IDX_W = ADDR_WIDTH - LSB;
    localparam int DEPTH = depth_of(DATA_WIDTH, ADDR_WIDTH);

    state_t state, state_nxt;
    logic [IDX_W-1:0]      clr_idx;
    logic [IDX_W-1:0]      widx;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] raw, wdata_sh, rdata_ext;
    logic [NB-1:0]         wmask;
    logic                  misalign, accept, do_store;

    assign widx     = addr[ADDR_WIDTH-1:LSB];
    assign raw      = mem[widx];
    assign accept   = ready && ram_ena && !rst;
    assign do_store = accept && wena && !misalign;

    dmem_lane_align #(
        .DATA_WIDTH (DATA_WIDTH),
        .LSB        (LSB)
    ) u_align (
        .off       (addr[LSB-1:0]),
        .size      (size),
        .sext      (sext),
        .data_in   (data_in),
        .raw       (raw),
        .wmask     (wmask),
        .wdata_sh  (wdata_sh),
        .rdata_ext (rdata_ext),
        .misalign  (misalign)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_CLEAR: if (clr_idx == IDX_W'(DEPTH - 1)) state_nxt = ST_RUN;
            default:  state_nxt = ST_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            clr_idx <= '0;
            ready   <= 1'b0;
        end else begin
            if (state == ST_CLEAR) clr_idx <= clr_idx + 1'b1;
            ready <= (state_nxt == ST_RUN);
        end
    end

    // Memory array carries no reset; the clear sequence zeroes it instead.
    always_ff @(posedge clk) begin
        if (!rst && state == ST_CLEAR) begin
            mem[clr_idx] <= '0;
        end else if (do_store) begin
            for (int k = 0; k < NB; k++) begin
                if (wmask[k]) mem[widx][8*k +: 8] <= wdata_sh[8*k +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_out <= '0;
            rvalid   <= 1'b0;
            err      <= 1'b0;
        end else begin
            rvalid <= 1'b0;
            err    <= 1'b0;
            if (accept) begin
                if (misalign) begin
                    err <= 1'b1;
                end else if (!wena) begin
                    data_out <= rdata_ext;
                    rvalid   <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed self-checking bench for dmem_ctrl (32-bit words, 256 entries).
module tb_dmem_ctrl;
    import dmem_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        ram_ena;
    logic        wena;
    logic [9:0]  addr;
    logic [1:0]  size;
    logic        sext;
    logic [31:0] data_in;
    logic [31:0] data_out;
    logic        rvalid;
    logic        err;
    logic        ready;

    int tests_run = 0;
    int tests_failed = 0;

    dmem_ctrl #(
        .DATA_WIDTH     (32),
        .ADDR_WIDTH     (10),
        .CLEAR_ON_RESET (1)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .ram_ena  (ram_ena),
        .wena     (wena),
        .addr     (addr),
        .size     (size),
        .sext     (sext),
        .data_in  (data_in),
        .data_out (data_out),
        .rvalid   (rvalid),
        .err      (err),
        .ready    (ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // One request cycle; outputs are sampled 1 time unit after the edge.
    task automatic req(input logic we, input logic [9:0] a, input logic [1:0] sz,
                       input logic sx, input logic [31:0] d);
        ram_ena = 1'b1;
        wena    = we;
        addr    = a;
        size    = sz;
        sext    = sx;
        data_in = d;
        @(posedge clk);
        #1;
        ram_ena = 1'b0;
        wena    = 1'b0;
    endtask

    task automatic idle_cycle();
        ram_ena = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic load_check(input string tag, input logic [9:0] a, input logic [1:0] sz,
                              input logic sx, input logic [31:0] exp);
        req(1'b0, a, sz, sx, 32'h0);
        check({tag, "_rvalid"}, {31'b0, rvalid}, 32'd1);
        check({tag, "_data"}, data_out, exp);
    endtask

    task automatic illegal_check(input string tag, input logic we, input logic [9:0] a,
                                 input logic [1:0] sz, input logic [31:0] hold);
        req(we, a, sz, 1'b1, 32'hDEADBEEF);
        check({tag, "_err"}, {31'b0, err}, 32'd1);
        check({tag, "_rvalid"}, {31'b0, rvalid}, 32'd0);
        check({tag, "_hold"}, data_out, hold);
        idle_cycle();
        check({tag, "_err_pulse"}, {31'b0, err}, 32'd0);
    endtask

    // Drives requests every cycle while the clear sequence runs.
    task automatic clear_phase(input int ncyc, input logic we, input string tag);
        int bad = 0;
        for (int i = 1; i <= ncyc; i++) begin
            ram_ena = 1'b1;
            wena    = we;
            addr    = we ? 10'h010 : (i[0] ? 10'h3FC : 10'h000);
            size    = SZ_WORD;
            sext    = 1'b0;
            data_in = 32'hFFFFFFFF;
            @(posedge clk);
            #1;
            if (rvalid || err) bad++;
            if (i < 256 && ready) bad++;
        end
        ram_ena = 1'b0;
        wena    = 1'b0;
        check({tag, "_quiet"}, bad, 32'd0);
        if (ncyc == 256) check({tag, "_ready"}, {31'b0, ready}, 32'd1);
    endtask

    initial begin
        rst = 1'b1; ram_ena = 1'b0; wena = 1'b0; addr = '0;
        size = SZ_WORD; sext = 1'b0; data_in = '0;
        @(posedge clk);
        #1;
        check("rst_ready", {31'b0, ready}, 32'd0);
        check("rst_rvalid", {31'b0, rvalid}, 32'd0);
        check("rst_err", {31'b0, err}, 32'd0);
        check("rst_data", data_out, 32'd0);
        rst = 1'b0;

        clear_phase(256, 1'b0, "clear");
        load_check("lw_zero_lo", 10'h000, SZ_WORD, 1'b0, 32'h00000000);
        load_check("lw_zero_hi", 10'h3FC, SZ_WORD, 1'b0, 32'h00000000);

        req(1'b1, 10'h010, SZ_WORD, 1'b0, 32'h12345678);
        check("sw_no_rvalid", {31'b0, rvalid}, 32'd0);
        load_check("lw_010", 10'h010, SZ_WORD, 1'b0, 32'h12345678);
        idle_cycle();
        check("idle_no_rvalid", {31'b0, rvalid}, 32'd0);
        check("idle_hold", data_out, 32'h12345678);

        req(1'b1, 10'h011, SZ_BYTE, 1'b0, 32'h000000AB);
        load_check("lb_011", 10'h011, SZ_BYTE, 1'b1, 32'hFFFFFFAB);
        load_check("lbu_011", 10'h011, SZ_BYTE, 1'b0, 32'h000000AB);
        load_check("lw_after_sb", 10'h010, SZ_WORD, 1'b0, 32'h1234AB78);
        load_check("lh_012", 10'h012, SZ_HALF, 1'b1, 32'h00001234);
        load_check("lh_010", 10'h010, SZ_HALF, 1'b1, 32'hFFFFAB78);
        load_check("lhu_010", 10'h010, SZ_HALF, 1'b0, 32'h0000AB78);

        req(1'b1, 10'h014, SZ_HALF, 1'b0, 32'h5555BEEF);
        req(1'b1, 10'h017, SZ_BYTE, 1'b0, 32'hFFFFFF80);
        load_check("lw_014", 10'h014, SZ_WORD, 1'b0, 32'h8000BEEF);
        load_check("lb_017", 10'h017, SZ_BYTE, 1'b1, 32'hFFFFFF80);

        illegal_check("lh_013", 1'b0, 10'h013, SZ_HALF, 32'hFFFFFF80);
        illegal_check("sw_012", 1'b1, 10'h012, SZ_WORD, 32'hFFFFFF80);
        illegal_check("rsvd_010", 1'b0, 10'h010, SZ_RSVD, 32'hFFFFFF80);
        load_check("lw_after_illegal", 10'h010, SZ_WORD, 1'b0, 32'h1234AB78);

        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst2_ready", {31'b0, ready}, 32'd0);
        clear_phase(100, 1'b1, "preclr");
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("midclr_ready", {31'b0, ready}, 32'd0);
        clear_phase(256, 1'b1, "reclear");
        load_check("lw_010_cleared", 10'h010, SZ_WORD, 1'b0, 32'h00000000);
        load_check("lw_014_cleared", 10'h014, SZ_WORD, 1'b0, 32'h00000000);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/dmem_ctrl.md
Name: dmem_ctrl

Overview:
- Parametrised data-memory block for the pipeline MEM stage; successor to the fixed 256x16 data RAM.
- Adds generic width/depth, byte-addressed sub-word loads/stores (byte/half/word) with sign/zero extension, alignment checking, registered 1-cycle read with valid strobe.
- Adds a reset-time clear sequencer that zeroes every word before accepting requests.

Parameters:
- DATA_WIDTH, 32, word width in bits; power of two, 16..64.
- ADDR_WIDTH, 10, byte-address width; DEPTH = 2**(ADDR_WIDTH-LSB) words, LSB = log2(DATA_WIDTH/8).
- CLEAR_ON_RESET, 1, 1 = run clear sequence after reset; 0 = skip it.

Ports:
- clk  in  1  clock, all state on posedge
- rst  in  1  reset; synchronous, active-high
- ram_ena  in  1  access request, sampled each edge
- wena  in  1  1 = store, 0 = load (qualified by ram_ena)
- addr  in  ADDR_WIDTH  byte address
- size  in  2  access size code (package constants)
- sext  in  1  loads: 1 = sign-extend, 0 = zero-extend
- data_in  in  DATA_WIDTH  store data, right-aligned (low bytes used)
- data_out  out  DATA_WIDTH  registered load result, right-aligned and extended
- rvalid  out  1  one-cycle pulse: data_out updated by a load
- err  out  1  one-cycle pulse: misaligned or reserved-size request
- ready  out  1  1 = accepting requests

Behaviour:
- Clock/reset: single clock clk; rst synchronous active-high. No tri-state outputs.
- Reset values: data_out=0, rvalid=0, err=0, ready=0, clr_idx=0. State becomes CLEAR if CLEAR_ON_RESET=1, otherwise RUN.
- FSM CLEAR:
  - Each cycle writes 0 to mem[clr_idx] and increments clr_idx.
  - On the edge that writes clr_idx=DEPTH-1, go to RUN and set ready=1.
  - CLEAR therefore takes exactly DEPTH cycles after rst deasserts.
- FSM RUN: ready=1; stays in RUN until rst.
- rst asserted in any state, including mid-CLEAR or mid-load: restart from reset values; clr_idx restarts at 0.
- Requests while ready=0 are ignored: no write, no rvalid, no err.
- Lanes: little-endian; lane k = bits [8k+7:8k]; byte offset off = addr[LSB-1:0]; word index = addr[ADDR_WIDTH-1:LSB].
- Alignment:
  - Half requires addr[0]=0.
  - Word requires off=0.
  - size=SZ_HALF with DATA_WIDTH=16 is a full-word access.
  - Reserved size 2'b11 is illegal.
- Illegal request with ram_ena=1: next edge err=1 for one cycle, rvalid=0, memory unchanged, data_out holds.
- Load (ram_ena=1, wena=0, legal): next edge data_out <= selected lanes shifted to bit 0, extended per sext; rvalid=1. Latency 1 cycle.
- Store (ram_ena=1, wena=1, legal):
  - Next edge writes the low 8/16/DATA_WIDTH bits of data_in into the selected lanes only; other lanes are preserved.
  - rvalid=0, data_out holds.
- A load on the cycle after a store to the same word returns the new data.
- No request: rvalid=0, err=0, data_out holds its last value.

Decomposition:
- Package dmem_pkg:
  - Size codes SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10, SZ_RSVD=2'b11.
  - FSM state encodings ST_CLEAR, ST_RUN.
  - LSB/DEPTH helper function (clog2).
- Sub-module dmem_lane_align: combinational; from off, size, sext, data_in and raw word it produces the lane write mask, shifted write data, extended load data and the misalign flag.
- dmem_ctrl holds the FSM, clear counter, memory array and output registers.

Test Plan (DATA_WIDTH=32, ADDR_WIDTH=10, DEPTH=256, CLEAR_ON_RESET=1):
- Clear and ready: rst high 1 cycle, then low; load words to 0x000, 0x3FC continuously.
  -> ready=0 and no rvalid for 256 cycles; ready=1 on cycle 256; loads return 0x00000000 with rvalid.
- Word store/load: store word 0x12345678 @0x010, load word @0x010 next cycle.
  -> one cycle later rvalid=1, data_out=0x12345678.
- Byte store and extension: store byte data_in=0x000000AB @0x011.
  -> lb @0x011 gives 0xFFFFFFAB; lbu @0x011 gives 0x000000AB; lw @0x010 gives 0x1234AB78.
- Half load: lh @0x012, sext=1.
  -> 0x00001234.
- Illegal accesses: lh @0x013; sw @0x012; size=2'b11 load @0x010.
  -> each gives err=1 for one cycle and rvalid=0; lw @0x010 still 0x1234AB78.
- Reset mid-clear and during CLEAR: rst pulsed at clr_idx=100; ram_ena=1 wena=1 during CLEAR.
  -> ready stays 0 for a further 256 cycles; no err, no rvalid, no write takes effect.
